// File: rtl/write_buffer_pkg.sv
// Shared cache definitions: write-type encodings and cache-line offset width.
// Both the cache and the write buffer import these.
package write_buffer_pkg;

    // Encodings carried on the wr_type buses
    typedef enum logic [2:0] {
        WT_WORD = 3'b010,
        WT_LINE = 3'b100
    } wr_type_e;

    // Number of byte-offset bits inside one cache line (16-byte lines)
    localparam int unsigned OFFSET_W = 4;

    // Address bits that identify a cache line
    localparam int unsigned TAG_W = 32 - OFFSET_W;

endpackage

// File: rtl/write_buffer.sv
// Write buffer between the cache and the bus: a DEPTH-entry circular FIFO of
// pending writes (words or full lines), drained in order whenever the bus is
// ready, with a read-miss hazard check against all pending line addresses.
// Build option: define WB_HAZARD_CHECK_EN for exact per-entry address
// comparison; otherwise chk_hit conservatively reports "buffer not empty".
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_wr_req,
    input  logic [2:0]        in_wr_type,
    input  logic [31:0]       in_wr_addr,
    input  logic [3:0]        in_wr_wstrb,
    input  logic [LINE_W-1:0] in_wr_data,
    output logic              in_wr_rdy,
    output logic              out_wr_req,
    output logic [2:0]        out_wr_type,
    output logic [31:0]       out_wr_addr,
    output logic [3:0]        out_wr_wstrb,
    output logic [LINE_W-1:0] out_wr_data,
    input  logic              out_wr_rdy,
    input  logic [31:0]       chk_addr,
    output logic              chk_hit,
    output logic              ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Entry storage, one array per field
    logic [2:0]        type_mem  [DEPTH];
    logic [31:0]       addr_mem  [DEPTH];
    logic [3:0]        wstrb_mem [DEPTH];
    logic [LINE_W-1:0] data_mem  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Copy of the most recently popped entry, shown on the head outputs when empty
    logic [2:0]        last_type;
    logic [31:0]       last_addr;
    logic [3:0]        last_wstrb;
    logic [LINE_W-1:0] last_data;

    logic push;
    logic pop;
    logic not_empty;

    assign not_empty  = (count != '0);
    assign in_wr_rdy  = (count != FULL_CNT);
    assign out_wr_req = not_empty && out_wr_rdy;
    assign push       = in_wr_req && in_wr_rdy;
    assign pop        = out_wr_req;

    // Capture the pushed entry at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_ptr]  <= in_wr_type;
            addr_mem[wr_ptr]  <= in_wr_addr;
            wstrb_mem[wr_ptr] <= in_wr_wstrb;
            data_mem[wr_ptr]  <= in_wr_data;
        end
    end

    // Pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_wr_req && !in_wr_rdy) begin
                ovf <= 1'b1;
            end
        end
    end

    // Remember the entry leaving the buffer so the head outputs hold it once empty
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_type  <= '0;
            last_addr  <= '0;
            last_wstrb <= '0;
            last_data  <= '0;
        end else if (pop) begin
            last_type  <= type_mem[rd_ptr];
            last_addr  <= addr_mem[rd_ptr];
            last_wstrb <= wstrb_mem[rd_ptr];
            last_data  <= data_mem[rd_ptr];
        end
    end

    // Head entry, or the last popped entry when nothing is pending
    always_comb begin
        out_wr_type  = last_type;
        out_wr_addr  = last_addr;
        out_wr_wstrb = last_wstrb;
        out_wr_data  = last_data;
        if (not_empty) begin
            out_wr_type  = type_mem[rd_ptr];
            out_wr_addr  = addr_mem[rd_ptr];
            out_wr_wstrb = wstrb_mem[rd_ptr];
            out_wr_data  = data_mem[rd_ptr];
        end
    end

`ifdef WB_HAZARD_CHECK_EN
    logic [OFFSET_W-1:0] unused_chk_offset;
    assign unused_chk_offset = chk_addr[OFFSET_W-1:0];

    // Line-address match against every occupied slot and the entry being pushed
    always_comb begin
        logic [PTR_W-1:0] rel;
        chk_hit = push && (in_wr_addr[31:OFFSET_W] == chk_addr[31:OFFSET_W]);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - rd_ptr;
            if (({1'b0, rel} < count) &&
                (addr_mem[i][31:OFFSET_W] == chk_addr[31:OFFSET_W])) begin
                chk_hit = 1'b1;
            end
        end
    end
`else
    logic unused_chk_addr;
    assign unused_chk_addr = ^chk_addr;

    assign chk_hit = not_empty;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer (DEPTH=4, LINE_W=128).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_write_buffer;
    import write_buffer_pkg::*;

    logic         clk;
    logic         resetn;
    logic         in_wr_req;
    logic [2:0]   in_wr_type;
    logic [31:0]  in_wr_addr;
    logic [3:0]   in_wr_wstrb;
    logic [127:0] in_wr_data;
    logic         in_wr_rdy;
    logic         out_wr_req;
    logic [2:0]   out_wr_type;
    logic [31:0]  out_wr_addr;
    logic [3:0]   out_wr_wstrb;
    logic [127:0] out_wr_data;
    logic         out_wr_rdy;
    logic [31:0]  chk_addr;
    logic         chk_hit;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    write_buffer #(.DEPTH(4), .LINE_W(128)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_wr_req    (in_wr_req),
        .in_wr_type   (in_wr_type),
        .in_wr_addr   (in_wr_addr),
        .in_wr_wstrb  (in_wr_wstrb),
        .in_wr_data   (in_wr_data),
        .in_wr_rdy    (in_wr_rdy),
        .out_wr_req   (out_wr_req),
        .out_wr_type  (out_wr_type),
        .out_wr_addr  (out_wr_addr),
        .out_wr_wstrb (out_wr_wstrb),
        .out_wr_data  (out_wr_data),
        .out_wr_rdy   (out_wr_rdy),
        .chk_addr     (chk_addr),
        .chk_hit      (chk_hit),
        .ovf          (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_push(input logic [31:0] a, input logic [127:0] d);
        in_wr_req   = 1'b1;
        in_wr_type  = WT_LINE;
        in_wr_addr  = a;
        in_wr_wstrb = 4'hF;
        in_wr_data  = d;
    endtask

    task automatic test_reset;
        resetn = 1'b0; in_wr_req = 1'b0; in_wr_type = '0; in_wr_addr = '0;
        in_wr_wstrb = '0; in_wr_data = '0; out_wr_rdy = 1'b0; chk_addr = '0;
        #3;
        total++; if (in_wr_rdy !== 1'b1) begin bad++; $display("FAIL rst_in_rdy got=%b exp=1", in_wr_rdy); end
        total++; if (out_wr_req !== 1'b0) begin bad++; $display("FAIL rst_out_req got=%b exp=0", out_wr_req); end
        total++; if (chk_hit !== 1'b0) begin bad++; $display("FAIL rst_chk_hit got=%b exp=0", chk_hit); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
        total++; if ({out_wr_type, out_wr_addr, out_wr_wstrb, out_wr_data} !== 167'd0) begin
            bad++; $display("FAIL rst_head got=%h/%h/%h/%h exp=0", out_wr_type, out_wr_addr, out_wr_wstrb, out_wr_data);
        end
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_single_line;
        out_wr_rdy = 1'b1;
        @(negedge clk); set_push(32'h1C00_0040, 128'hDEAD_BEEF_0000_0001_0000_0002_CAFE_F00D);
        #1;
        total++; if (out_wr_req !== 1'b0) begin bad++; $display("FAIL line_no_bypass got=%b exp=0", out_wr_req); end
        @(negedge clk); in_wr_req = 1'b0;
        #1;
        total++; if (out_wr_req !== 1'b1) begin bad++; $display("FAIL line_req got=%b exp=1", out_wr_req); end
        total++; if (out_wr_addr !== 32'h1C00_0040) begin bad++; $display("FAIL line_addr got=%h exp=1c000040", out_wr_addr); end
        total++; if (out_wr_type !== 3'b100) begin bad++; $display("FAIL line_type got=%b exp=100", out_wr_type); end
        total++; if (out_wr_data !== 128'hDEAD_BEEF_0000_0001_0000_0002_CAFE_F00D) begin
            bad++; $display("FAIL line_data got=%h exp=deadbeef000000010000000 2cafef00d", out_wr_data);
        end
        @(negedge clk); #1;
        total++; if (out_wr_req !== 1'b0) begin bad++; $display("FAIL line_single_pulse got=%b exp=0", out_wr_req); end
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL line_count got=%0d exp=0", dut.count); end
        total++; if (out_wr_addr !== 32'h1C00_0040) begin bad++; $display("FAIL line_hold_addr got=%h exp=1c000040", out_wr_addr); end
    endtask

    task automatic test_fill_ovf;
        logic [31:0] a;
        out_wr_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); set_push(32'h0000_1000 + 32'(k) * 32'h10, 128'(32'hA000 + k));
            #1;
            total++; if (in_wr_rdy !== 1'b1) begin bad++; $display("FAIL fill_rdy_%0d got=%b exp=1", k, in_wr_rdy); end
        end
        @(negedge clk); in_wr_req = 1'b0;
        #1;
        total++; if (in_wr_rdy !== 1'b0) begin bad++; $display("FAIL full_rdy got=%b exp=0", in_wr_rdy); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pre_ovf got=%b exp=0", ovf); end
        @(negedge clk); set_push(32'h0000_9990, 128'hBAD);
        @(negedge clk); in_wr_req = 1'b0;
        #1;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        total++; if (dut.count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", dut.count); end
        @(negedge clk); out_wr_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            a = 32'h0000_1000 + 32'(k) * 32'h10;
            total++; if (out_wr_req !== 1'b1) begin bad++; $display("FAIL drain_req_%0d got=%b exp=1", k, out_wr_req); end
            total++; if (out_wr_addr !== a) begin bad++; $display("FAIL drain_addr_%0d got=%h exp=%h", k, out_wr_addr, a); end
            total++; if (out_wr_data !== 128'(32'hA000 + k)) begin
                bad++; $display("FAIL drain_data_%0d got=%h exp=%h", k, out_wr_data, 128'(32'hA000 + k));
            end
            @(negedge clk);
        end
        #1;
        total++; if (out_wr_req !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_wr_req); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        out_wr_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); set_push(32'h0002_0000 + 32'(k) * 32'h100, 128'(32'hB000 + k));
        end
        @(negedge clk); set_push(32'h0002_0300, 128'(32'hB003)); out_wr_rdy = 1'b1;
        #1;
        total++; if (out_wr_req !== 1'b1) begin bad++; $display("FAIL b2b_req got=%b exp=1", out_wr_req); end
        total++; if (out_wr_addr !== 32'h0002_0000) begin bad++; $display("FAIL b2b_head got=%h exp=00020000", out_wr_addr); end
        @(negedge clk); in_wr_req = 1'b0; out_wr_rdy = 1'b0;
        #1;
        total++; if (dut.count !== 3'd3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", dut.count); end
        @(negedge clk); out_wr_rdy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            a = 32'h0002_0000 + 32'(k) * 32'h100;
            total++; if (out_wr_addr !== a || out_wr_data !== 128'(32'hB000 + k) || out_wr_req !== 1'b1) begin
                bad++; $display("FAIL wrap_pop_%0d got=%b/%h/%h exp=1/%h/%h", k, out_wr_req, out_wr_addr, out_wr_data, a, 128'(32'hB000 + k));
            end
            @(negedge clk);
        end
        #1;
        total++; if (out_wr_req !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b exp=0", out_wr_req); end
    endtask

    task automatic test_hazard;
        logic exp_push, exp_far;
`ifdef WB_HAZARD_CHECK_EN
        exp_push = 1'b1; exp_far = 1'b0;
`else
        exp_push = 1'b0; exp_far = 1'b1;
`endif
        out_wr_rdy = 1'b0;
        @(negedge clk); chk_addr = 32'h0000_1234;
        #1;
        total++; if (chk_hit !== 1'b0) begin bad++; $display("FAIL hz_empty got=%b exp=0", chk_hit); end
        @(negedge clk); set_push(32'h0000_1230, 128'h1230);
        #1;
        total++; if (chk_hit !== exp_push) begin bad++; $display("FAIL hz_pushing got=%b exp=%b", chk_hit, exp_push); end
        @(negedge clk); in_wr_req = 1'b0; chk_addr = 32'h0000_123C;
        #1;
        total++; if (chk_hit !== 1'b1) begin bad++; $display("FAIL hz_same_line got=%b exp=1", chk_hit); end
        chk_addr = 32'h0000_1240;
        #1;
        total++; if (chk_hit !== exp_far) begin bad++; $display("FAIL hz_next_line got=%b exp=%b", chk_hit, exp_far); end
    endtask

    task automatic test_reset_mid_drain;
        @(negedge clk); set_push(32'h0000_5550, 128'h5550);
        @(negedge clk); in_wr_req = 1'b0; out_wr_rdy = 1'b1;
        #1;
        total++; if (out_wr_req !== 1'b1 || dut.count !== 3'd2) begin
            bad++; $display("FAIL md_pre got=%b/%0d exp=1/2", out_wr_req, dut.count);
        end
        #1; resetn = 1'b0;
        #1;
        total++; if (out_wr_req !== 1'b0) begin bad++; $display("FAIL md_req got=%b exp=0", out_wr_req); end
        total++; if (in_wr_rdy !== 1'b1 || chk_hit !== 1'b0 || ovf !== 1'b0 || out_wr_addr !== 32'd0) begin
            bad++; $display("FAIL md_rst_outs got=%b/%b/%b/%h exp=1/0/0/0", in_wr_rdy, chk_hit, ovf, out_wr_addr);
        end
        @(negedge clk); resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (out_wr_req !== 1'b0 || in_wr_rdy !== 1'b1) begin
                bad++; $display("FAIL md_stale_%0d got=%b/%b exp=0/1", k, out_wr_req, in_wr_rdy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_word;
        out_wr_rdy = 1'b1;
        @(negedge clk);
        in_wr_req = 1'b1; in_wr_type = WT_WORD; in_wr_addr = 32'hBFAF_8000;
        in_wr_wstrb = 4'b0011; in_wr_data = 128'h1234_5678;
        @(negedge clk); in_wr_req = 1'b0;
        #1;
        total++; if (out_wr_req !== 1'b1 || out_wr_type !== 3'b010) begin
            bad++; $display("FAIL word_req_type got=%b/%b exp=1/010", out_wr_req, out_wr_type);
        end
        total++; if (out_wr_wstrb !== 4'b0011) begin bad++; $display("FAIL word_wstrb got=%b exp=0011", out_wr_wstrb); end
        total++; if (out_wr_addr !== 32'hBFAF_8000 || out_wr_data !== 128'h1234_5678) begin
            bad++; $display("FAIL word_addr_data got=%h/%h exp=bfaf8000/12345678", out_wr_addr, out_wr_data);
        end
        @(negedge clk); #1;
        total++; if (out_wr_req !== 1'b0) begin bad++; $display("FAIL word_done got=%b exp=0", out_wr_req); end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_fill_ovf();
        test_back_to_back();
        test_hazard();
        test_reset_mid_drain();
        test_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
